// File: rtl/seq_div_mod_unit_if.sv
// Start/Busy/Done handshake and result channel of the sequential divider.
// The requester drives Start and the operands; the divider returns status
// flags and the 32-bit sign-replicated quotient/remainder channel words.
interface seq_div_mod_unit_if #(
    parameter int WIDTH = 16
);
    logic                 Start;
    logic [WIDTH-1:0]     InputA;
    logic [WIDTH-1:0]     InputB;
    logic                 Busy;
    logic                 Done;
    logic [2*WIDTH-1:0]   outputDIV;
    logic [2*WIDTH-1:0]   outputMOD;
    logic                 DIVerror;

    modport master (
        output Start, InputA, InputB,
        input  Busy, Done, outputDIV, outputMOD, DIVerror
    );

    modport slave (
        input  Start, InputA, InputB,
        output Busy, Done, outputDIV, outputMOD, DIVerror
    );
endinterface

// File: rtl/seq_div_mod_unit.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// quotient and remainder produced together. Divide-by-zero completes in a
// single cycle with an all-ones quotient, remainder = dividend and an error
// flag. Results are widened to 2*WIDTH by replicating bit WIDTH-1.
module seq_div_mod_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_div_mod_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     quo_q, quo_d;
    logic [WIDTH-1:0]     div_q, div_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [2*WIDTH-1:0]   out_div_q, out_div_d;
    logic [2*WIDTH-1:0]   out_mod_q, out_mod_d;

    logic [WIDTH:0]       trial;
    logic                 fits;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;

    // Widen a WIDTH-bit result to the channel format by copying its top bit.
    function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
        return {{WIDTH{v[WIDTH-1]}}, v};
    endfunction

    // One restoring step: shift the next dividend bit into the partial
    // remainder and subtract the divisor when it fits. When it fits the
    // difference is below the divisor, so the low WIDTH bits are exact.
    always_comb begin
        trial    = {rem_q, quo_q[WIDTH-1]};
        fits     = (trial >= {1'b0, div_q});
        rem_step = fits ? (trial[WIDTH-1:0] - div_q) : trial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], fits};
    end

    // Next-state and datapath control; result registers only change on completion.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        div_d     = div_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        out_div_d = out_div_q;
        out_mod_d = out_mod_q;

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (bus.Start) begin
                    div_d = bus.InputB;
                    quo_d = bus.InputA;
                    if (bus.InputB != '0) begin
                        rem_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        out_div_d = sext({WIDTH{1'b1}});
                        out_mod_d = sext(bus.InputA);
                        err_d     = 1'b1;
                        done_d    = 1'b1;
                        state_d   = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = rem_step;
                quo_d = quo_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    out_div_d = sext(quo_step);
                    out_mod_d = sext(rem_step);
                    err_d     = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any run and clears all outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            out_div_q <= '0;
            out_mod_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            div_q     <= div_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            out_div_q <= out_div_d;
            out_mod_q <= out_mod_d;
        end
    end

    assign bus.Busy      = busy_q;
    assign bus.Done      = done_q;
    assign bus.DIVerror  = err_q;
    assign bus.outputDIV = out_div_q;
    assign bus.outputMOD = out_mod_q;
endmodule

// File: tb/tb_seq_div_mod_unit.sv
// Directed and randomized bench for seq_div_mod_unit. Expected results come
// from plain integer division (/ and %) plus the divide-by-zero rule; timing
// expectations come from the documented latencies.
module tb_seq_div_mod_unit;
    logic clk;
    logic rst_n;
    int   compares;
    int   fails;

    seq_div_mod_unit_if #(.WIDTH(16)) bus ();

    seq_div_mod_unit #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: quotient and remainder in channel format.
    function automatic logic [31:0] ref_q(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q;
        q = (b == 16'd0) ? 16'hFFFF : 16'(a / b);
        return {{16{q[15]}}, q};
    endfunction

    function automatic logic [31:0] ref_r(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] r;
        r = (b == 16'd0) ? a : 16'(a % b);
        return {{16{r[15]}}, r};
    endfunction

    // Issue one operation from IDLE, wait for Done (bounded), check timing,
    // results, and that Done is a single-cycle pulse.
    task automatic run_and_check(input string tag, input logic [15:0] a, input logic [15:0] b);
        int k;
        int busy_n;
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.InputA = a;
        bus.InputB = b;
        @(negedge clk);
        bus.Start = 1'b0;
        k = 0;
        busy_n = 0;
        while (!bus.Done && k < 40) begin
            if (bus.Busy) busy_n++;
            @(negedge clk);
            k++;
        end
        chk({tag, "_latency"}, 32'(k), (b == 16'd0) ? 32'd0 : 32'd16);
        chk({tag, "_busy_cycles"}, 32'(busy_n), (b == 16'd0) ? 32'd0 : 32'd16);
        chk({tag, "_busy_at_done"}, 32'(bus.Busy), 32'd0);
        chk({tag, "_q"}, bus.outputDIV, ref_q(a, b));
        chk({tag, "_r"}, bus.outputMOD, ref_r(a, b));
        chk({tag, "_err"}, 32'(bus.DIVerror), (b == 16'd0) ? 32'd1 : 32'd0);
        @(negedge clk);
        chk({tag, "_done_pulse_end"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int k;
        int m;
        logic [15:0] cur_a, cur_b;
        logic [15:0] q16, r16;

        compares   = 0;
        fails      = 0;
        rst_n      = 1'b0;
        bus.Start  = 1'b0;
        bus.InputA = '0;
        bus.InputB = '0;

        // Reset state
        #12;
        chk("rst_busy", 32'(bus.Busy), 32'd0);
        chk("rst_done", 32'(bus.Done), 32'd0);
        chk("rst_q", bus.outputDIV, 32'd0);
        chk("rst_r", bus.outputMOD, 32'd0);
        chk("rst_err", 32'(bus.DIVerror), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic division, divide-by-zero, extremes
        run_and_check("basic", 16'd100, 16'd7);
        chk("basic_q_const", bus.outputDIV, 32'd14);
        chk("basic_r_const", bus.outputMOD, 32'd2);
        run_and_check("divzero", 16'd21, 16'd0);
        chk("divzero_q_const", bus.outputDIV, 32'hFFFFFFFF);
        chk("divzero_r_const", bus.outputMOD, 32'd21);
        run_and_check("maxdiv", 16'hFFFF, 16'd1);
        chk("maxdiv_q_const", bus.outputDIV, 32'hFFFFFFFF);
        run_and_check("equal", 16'h7FFF, 16'h7FFF);
        chk("equal_q_const", bus.outputDIV, 32'd1);
        run_and_check("smallA", 16'd3, 16'd40000);

        // Back-to-back with an ignored mid-run Start
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.InputA = 16'd29450;
        bus.InputB = 16'd16450;
        @(negedge clk);
        bus.Start = 1'b0;
        k = 0;
        while (!bus.Done && k < 40) begin
            if (k == 5) begin
                bus.Start  = 1'b1;
                bus.InputA = 16'd5;
                bus.InputB = 16'd1;
            end else if (k == 6) begin
                bus.Start  = 1'b0;
                bus.InputA = 16'd777;
                bus.InputB = 16'd9;
            end
            @(negedge clk);
            k++;
        end
        chk("b2b_first_latency", 32'(k), 32'd16);
        chk("b2b_first_q", bus.outputDIV, 32'd1);
        chk("b2b_first_r", bus.outputMOD, 32'd13000);
        bus.Start  = 1'b1;
        bus.InputA = 16'd32400;
        bus.InputB = 16'd16200;
        @(negedge clk);
        bus.Start = 1'b0;
        m = 1;
        chk("b2b_done_falls", 32'(bus.Done), 32'd0);
        chk("b2b_busy_rises", 32'(bus.Busy), 32'd1);
        chk("b2b_hold_q_midrun", bus.outputDIV, 32'd1);
        while (!bus.Done && m < 40) begin
            @(negedge clk);
            m++;
        end
        chk("b2b_spacing", 32'(m), 32'd17);
        chk("b2b_second_q", bus.outputDIV, 32'd2);
        chk("b2b_second_r", bus.outputMOD, 32'd0);
        chk("b2b_second_err", 32'(bus.DIVerror), 32'd0);

        // Asynchronous reset in the middle of a run
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.InputA = 16'd1000;
        bus.InputB = 16'd3;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.Busy), 32'd0);
        chk("midrst_done", 32'(bus.Done), 32'd0);
        chk("midrst_q", bus.outputDIV, 32'd0);
        chk("midrst_r", bus.outputMOD, 32'd0);
        chk("midrst_err", 32'(bus.DIVerror), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(bus.Done), 32'd0);
        end
        rst_n = 1'b1;
        run_and_check("after_rst", 16'd1000, 16'd3);
        chk("after_rst_q_const", bus.outputDIV, 32'd333);
        chk("after_rst_r_const", bus.outputMOD, 32'd1);

        // Randomized sweep, each new operation issued during the Done cycle
        cur_a = 16'($urandom);
        cur_b = 16'($urandom_range(1, 65535));
        @(negedge clk);
        bus.Start  = 1'b1;
        bus.InputA = cur_a;
        bus.InputB = cur_b;
        @(negedge clk);
        bus.Start = 1'b0;
        k = 0;
        for (int i = 0; i < 500; i++) begin
            while (!bus.Done && k < 40) begin
                @(negedge clk);
                k++;
            end
            q16 = bus.outputDIV[15:0];
            r16 = bus.outputMOD[15:0];
            chk("rand_latency", 32'(k), 32'd16);
            chk("rand_identity", 32'(q16) * 32'(cur_b) + 32'(r16), 32'(cur_a));
            chk("rand_r_lt_b", 32'(r16 < cur_b), 32'd1);
            chk("rand_q_ext", bus.outputDIV, ref_q(cur_a, cur_b));
            chk("rand_r_ext", bus.outputMOD, ref_r(cur_a, cur_b));
            if (i < 499) begin
                cur_a = 16'($urandom);
                cur_b = 16'($urandom_range(1, 65535));
                bus.Start  = 1'b1;
                bus.InputA = cur_a;
                bus.InputB = cur_b;
                @(negedge clk);
                bus.Start = 1'b0;
                k = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
